apb_multi_slave_master: RTL and testbench
=========================================

# apb_multi_slave_master

Parametrised APB (AMBA3-style) master that turns a single-beat command/response interface into APB SETUP/ACCESS transfers to one of `NUM_SLV` slaves. It decodes the slave from an address field and returns read data and error status. It honours PREADY wait states and PSLVERR, and can optionally abort stalled transfers with a timeout. It sits between the test/control logic and the APB slave fabric, and replaces the fixed two-slave, fixed-address master.

## Interface
Parameters:
- `DATA_W`, 32: PWDATA/PRDATA width.
- `ADDR_W`, 16: PADDR width.
- `NUM_SLV`, 4: number of slaves, 1..16.
- `SEL_LSB`, 12: LSB of the slave-select field in the address; field width `IDX_W = max(1, $clog2(NUM_SLV))`, requires `SEL_LSB+IDX_W <= ADDR_W`.
- `TIMEOUT_CYC`, 16: ACCESS cycles allowed before abort (used only with the timeout macro), ≥2.

Ports (one clock; reset is asynchronous and active-low):
- `PCLK` in 1: clock.
- `PRESET_n` in 1: async active-low reset.
- `cmd_valid_i` in 1: command request.
- `cmd_ready_o` out 1: command accepted when high with `cmd_valid_i`.
- `cmd_write_i` in 1: 1 = write, 0 = read.
- `cmd_addr_i` in ADDR_W: target address.
- `cmd_wdata_i` in DATA_W: write data.
- `rsp_valid_o` out 1: one-cycle response pulse.
- `rsp_rdata_o` out DATA_W: read data; 0 for writes and errors.
- `rsp_err_o` out 1: PSLVERR, decode error or timeout.
- `PADDR_o` out ADDR_W: APB address.
- `PWDATA_o` out DATA_W: APB write data.
- `PWRITE_o` out 1: APB direction.
- `PSEL_o` out NUM_SLV: one-hot slave select.
- `PENABLE_o` out 1: APB enable.
- `PREADY_i` in NUM_SLV: per-slave ready.
- `PRDATA_i` in NUM_SLV*DATA_W: slave k occupies `[k*DATA_W +: DATA_W]`.
- `PSLVERR_i` in NUM_SLV: per-slave error.

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - `cmd_ready_o`=1.
  - On `cmd_valid_i`, capture write, addr, wdata and index `idx = cmd_addr_i[SEL_LSB +: IDX_W]`.
  - If `idx < NUM_SLV`, go to SETUP.
  - Otherwise it is a decode error: no APB activity, stay IDLE, and pulse `rsp_valid_o`/`rsp_err_o`=1 next cycle.
- SETUP:
  - `PSEL_o[idx]`=1, `PENABLE_o`=0.
  - PADDR/PWDATA/PWRITE driven from the captured registers.
  - Always → ACCESS.
- ACCESS:
  - `PSEL_o[idx]`=1, `PENABLE_o`=1, all address/data/control held stable.
  - On `PREADY_i[idx]`: register `rsp_err_o = PSLVERR_i[idx]` and `rsp_rdata_o = (read & ~PSLVERR) ? PRDATA_i[idx] : 0`, then → IDLE.
  - Otherwise remain in ACCESS.
- Only `PREADY_i[idx]`, `PRDATA_i[idx]` and `PSLVERR_i[idx]` of the selected slave are observed; all other slaves' inputs are ignored.
- In IDLE, `PSEL_o`, `PENABLE_o`, `PADDR_o`, `PWDATA_o` and `PWRITE_o` are all 0.
- `cmd_*` inputs are don't-care except in IDLE.
- `rsp_rdata_o`/`rsp_err_o` are valid only while `rsp_valid_o`=1 and are 0 otherwise.
- Reset mid-transfer: all outputs return to 0 immediately (async), the state goes to IDLE, and no response is emitted.

## Timing
- Reset values: `cmd_ready_o`=1 after reset release; every other output is 0.
- Command accepted at edge E0 → SETUP in cycle 1 → ACCESS in cycle 2.
- `PREADY` high in cycle 2 → `rsp_valid_o` in cycle 3.
- Minimum command-to-response latency is 3 cycles; each wait state adds 1.
- `rsp_valid_o` coincides with IDLE (`cmd_ready_o`=1), so a back-to-back command is accepted in the response cycle. Peak throughput is 1 transfer per 3 cycles.
- Decode error: response 1 cycle after acceptance; `cmd_ready_o` stays 1.
- `PSEL_o` is never multi-hot, and `PENABLE_o` is never high without PSEL.

## Configuration
- `APB_MASTER_TIMEOUT_EN` defined:
  - A counter clears on SETUP→ACCESS and increments each ACCESS cycle with `PREADY_i[idx]`=0.
  - When it reaches `TIMEOUT_CYC`, the transfer is aborted: PSEL/PENABLE drop, state → IDLE, and `rsp_valid_o`=1, `rsp_err_o`=1, `rsp_rdata_o`=0 in the next cycle.
  - If PREADY arrives in the same cycle the count would expire, PREADY wins.
- `APB_MASTER_TIMEOUT_EN` undefined:
  - No counter is built, and ACCESS waits indefinitely for PREADY.

## Test plan
- Write addr 0x1234 (slave 1), data 0xDEADBEEF, slave 1 PREADY=1 immediately → PSEL_o=0b0010 for 2 cycles, PENABLE in cycle 2 only, rsp_valid in cycle 3 with err=0 and rdata=0.
- Read addr 0x3010, slave 3 PREADY after 4 wait states, PRDATA=0xA5A5_0001 → ACCESS lasts 5 cycles, response rdata=0xA5A50001, err=0; slave 0–2 inputs toggling have no effect.
- Read of slave 2 with PSLVERR=1 and PRDATA=0xFFFF → rsp_err=1, rdata=0.
- NUM_SLV=3, addr 0x3000 → no PSEL, rsp_valid+err one cycle after accept; a back-to-back valid command in that cycle is accepted.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYC=16, slave 0 never ready → abort after 16 ACCESS cycles, err=1; without the macro, still in ACCESS after 100 cycles.
- Assert PRESET_n low during ACCESS → PSEL/PENABLE/PADDR drop to 0 asynchronously, no rsp_valid; after release, a new write completes normally.

Source files
------------

// File: rtl/apb_multi_slave_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_multi_slave_master
// Brief    : Single-beat command/response to APB master for NUM_SLV slaves.
//            The slave is decoded from cmd_addr_i[SEL_LSB +: IDX_W]; PREADY
//            wait states and PSLVERR are honoured. Out-of-range indices are
//            answered with an error response and no bus activity.
// Options  : define APB_MASTER_TIMEOUT_EN to abort transfers that stay in
//            ACCESS for TIMEOUT_CYC cycles without PREADY.
// Revision : 1.0 - initial release
// ============================================================================
module apb_multi_slave_master #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int NUM_SLV     = 4,
  parameter int SEL_LSB     = 12,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET_n,
  // command / response side
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [ADDR_W-1:0]         cmd_addr_i,
  input  logic [DATA_W-1:0]         cmd_wdata_i,
  output logic                      rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      rsp_err_o,
  // APB side
  output logic [ADDR_W-1:0]         PADDR_o,
  output logic [DATA_W-1:0]         PWDATA_o,
  output logic                      PWRITE_o,
  output logic [NUM_SLV-1:0]        PSEL_o,
  output logic                      PENABLE_o,
  input  logic [NUM_SLV-1:0]        PREADY_i,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA_i,
  input  logic [NUM_SLV-1:0]        PSLVERR_i
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  // One extra bit so NUM_SLV itself is representable for the range compare
  localparam logic [IDX_W:0] c_NUM_SLV = (IDX_W + 1)'(NUM_SLV);

  // Parameter sanity checks, evaluated at elaboration
  if ((NUM_SLV < 1) || (NUM_SLV > 16) || (SEL_LSB + IDX_W > ADDR_W) ||
      (TIMEOUT_CYC < 2)) begin : g_cfg_check
    $error("apb_multi_slave_master: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;

  logic [IDX_W-1:0]    w_cmd_idx;
  logic                w_cmd_ok;
  logic [NUM_SLV-1:0]  w_cmd_onehot;
  logic                w_accept;
  logic                w_sel_ready;
  logic                w_sel_slverr;
  logic [DATA_W-1:0]   w_sel_rdata;

`ifdef APB_MASTER_TIMEOUT_EN
  // Counter only needs to reach TIMEOUT_CYC-1: the expiring cycle aborts
  localparam int                c_TMO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYC - 1);
  logic [c_TMO_W-1:0]           r_tmo_cnt;
`endif

  assign w_cmd_idx = cmd_addr_i[SEL_LSB +: IDX_W];
  assign w_cmd_ok  = ({1'b0, w_cmd_idx} < c_NUM_SLV);
  assign w_accept  = cmd_valid_i & cmd_ready_o;

  // Decode the incoming index into a one-hot select (empty when out of range)
  always_comb begin
    w_cmd_onehot = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      w_cmd_onehot[k] = (w_cmd_idx == IDX_W'(k));
    end
  end

  // Pick out the inputs of the currently addressed slave; others are ignored
  always_comb begin
    w_sel_ready  = 1'b0;
    w_sel_slverr = 1'b0;
    w_sel_rdata  = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_sel_ready  = PREADY_i[k];
        w_sel_slverr = PSLVERR_i[k];
        w_sel_rdata  = PRDATA_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // Transfer FSM with all outputs registered; response fields default to 0
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      cmd_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
      PADDR_o     <= '0;
      PWDATA_o    <= '0;
      PWRITE_o    <= 1'b0;
      PSEL_o      <= '0;
      PENABLE_o   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      r_tmo_cnt   <= '0;
`endif
    end else begin
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
      case (r_state)
        S_IDLE: begin
          cmd_ready_o <= 1'b1;
          if (w_accept) begin
            if (w_cmd_ok) begin
              r_state     <= S_SETUP;
              cmd_ready_o <= 1'b0;
              r_idx       <= w_cmd_idx;
              PSEL_o      <= w_cmd_onehot;
              PADDR_o     <= cmd_addr_i;
              PWDATA_o    <= cmd_wdata_i;
              PWRITE_o    <= cmd_write_i;
            end else begin
              // Decode error: answer immediately, bus stays quiet
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          r_state   <= S_ACCESS;
          PENABLE_o <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
          r_tmo_cnt <= '0;
`endif
        end
        S_ACCESS: begin
          if (w_sel_ready) begin
            r_state     <= S_IDLE;
            cmd_ready_o <= 1'b1;
            PSEL_o      <= '0;
            PENABLE_o   <= 1'b0;
            PADDR_o     <= '0;
            PWDATA_o    <= '0;
            PWRITE_o    <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= w_sel_slverr;
            rsp_rdata_o <= (!PWRITE_o && !w_sel_slverr) ? w_sel_rdata : '0;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (r_tmo_cnt == c_TMO_LAST) begin
            // Slave stalled too long: drop the bus and report an error
            r_state     <= S_IDLE;
            cmd_ready_o <= 1'b1;
            PSEL_o      <= '0;
            PENABLE_o   <= 1'b0;
            PADDR_o     <= '0;
            PWDATA_o    <= '0;
            PWRITE_o    <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_multi_slave_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_multi_slave_master
// Brief    : Directed scoreboard bench for apb_multi_slave_master. A 4-slave
//            instance carries the main transfers; a 3-slave instance covers
//            decode errors and back-to-back acceptance. Timeout expectations
//            follow APB_MASTER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_multi_slave_master;

  logic PCLK = 1'b0;
  logic PRESET_n = 1'b1;
  always #5 PCLK = ~PCLK;

  // 4-slave instance
  logic        cmd_valid4 = 0, cmd_write4 = 0, cmd_ready4;
  logic [15:0] cmd_addr4 = '0;
  logic [31:0] cmd_wdata4 = '0;
  logic        rsp_valid4, rsp_err4;
  logic [31:0] rsp_rdata4;
  logic [15:0] paddr4;
  logic [31:0] pwdata4;
  logic        pwrite4, penable4;
  logic [3:0]  psel4;
  logic [3:0]  pready4 = '0, pslverr4 = '0;
  logic [127:0] prdata4 = '0;

  // 3-slave instance
  logic        cmd_valid3 = 0, cmd_write3 = 0, cmd_ready3;
  logic [15:0] cmd_addr3 = '0;
  logic [31:0] cmd_wdata3 = '0;
  logic        rsp_valid3, rsp_err3;
  logic [31:0] rsp_rdata3;
  logic [15:0] paddr3;
  logic [31:0] pwdata3;
  logic        pwrite3, penable3;
  logic [2:0]  psel3;
  logic [2:0]  pready3 = '0, pslverr3 = '0;
  logic [95:0] prdata3 = '0;

  apb_multi_slave_master #(.DATA_W(32), .ADDR_W(16), .NUM_SLV(4), .SEL_LSB(12),
                           .TIMEOUT_CYC(16)) u_dut4 (
    .PCLK(PCLK), .PRESET_n(PRESET_n),
    .cmd_valid_i(cmd_valid4), .cmd_ready_o(cmd_ready4), .cmd_write_i(cmd_write4),
    .cmd_addr_i(cmd_addr4), .cmd_wdata_i(cmd_wdata4),
    .rsp_valid_o(rsp_valid4), .rsp_rdata_o(rsp_rdata4), .rsp_err_o(rsp_err4),
    .PADDR_o(paddr4), .PWDATA_o(pwdata4), .PWRITE_o(pwrite4), .PSEL_o(psel4),
    .PENABLE_o(penable4), .PREADY_i(pready4), .PRDATA_i(prdata4), .PSLVERR_i(pslverr4)
  );

  apb_multi_slave_master #(.DATA_W(32), .ADDR_W(16), .NUM_SLV(3), .SEL_LSB(12),
                           .TIMEOUT_CYC(16)) u_dut3 (
    .PCLK(PCLK), .PRESET_n(PRESET_n),
    .cmd_valid_i(cmd_valid3), .cmd_ready_o(cmd_ready3), .cmd_write_i(cmd_write3),
    .cmd_addr_i(cmd_addr3), .cmd_wdata_i(cmd_wdata3),
    .rsp_valid_o(rsp_valid3), .rsp_rdata_o(rsp_rdata3), .rsp_err_o(rsp_err3),
    .PADDR_o(paddr3), .PWDATA_o(pwdata3), .PWRITE_o(pwrite3), .PSEL_o(psel3),
    .PENABLE_o(penable3), .PREADY_i(pready3), .PRDATA_i(prdata3), .PSLVERR_i(pslverr3)
  );

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];   // {err, rdata} expected from u_dut4

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          tgt;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } xfer_t;

  xfer_t vec[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Target gets the programmed response; every other slave shows the opposite
  // handshake and garbage so any cross-talk changes the observed result.
  task automatic drive_slaves(input xfer_t v, input logic rdy);
    for (int k = 0; k < 4; k++) begin
      if (k == v.tgt) begin
        pready4[k]            = rdy;
        pslverr4[k]           = v.slverr;
        prdata4[k*32 +: 32]   = v.prdata;
      end else begin
        pready4[k]            = ~rdy;
        pslverr4[k]           = ~v.slverr;
        prdata4[k*32 +: 32]   = 32'hBAD0_0000 | 32'(k);
      end
    end
  endtask

  task automatic run_xfer(input xfer_t v);
    logic [3:0] oh;
    oh = 4'b0001 << v.tgt;
    @(negedge PCLK);
    check("cmd_ready_idle", 64'(cmd_ready4), 64'd1);
    cmd_valid4 = 1'b1; cmd_write4 = v.wr; cmd_addr4 = v.addr; cmd_wdata4 = v.wdata;
    exp_q.push_back({v.exp_err, v.exp_rdata});
    @(negedge PCLK);
    cmd_valid4 = 1'b0; cmd_write4 = ~v.wr; cmd_addr4 = 16'hFFFF; cmd_wdata4 = 32'h0;
    check("setup_psel", 64'(psel4), 64'(oh));
    check("setup_penable", 64'(penable4), 64'd0);
    check("setup_paddr", 64'(paddr4), 64'(v.addr));
    check("setup_pwrite", 64'(pwrite4), 64'(v.wr));
    check("setup_pwdata", 64'(pwdata4), 64'(v.wdata));
    check("setup_cmd_ready", 64'(cmd_ready4), 64'd0);
    drive_slaves(v, 1'b0);
    for (int i = 0; i <= v.waits; i++) begin
      @(negedge PCLK);
      check("access_psel", 64'(psel4), 64'(oh));
      check("access_penable", 64'(penable4), 64'd1);
      check("access_paddr", 64'(paddr4), 64'(v.addr));
      check("access_pwdata", 64'(pwdata4), 64'(v.wdata));
      check("access_rsp_valid", 64'(rsp_valid4), 64'd0);
      drive_slaves(v, (i == v.waits));
    end
    @(negedge PCLK);
    check("rsp_cycle_valid", 64'(rsp_valid4), 64'd1);
    check("rsp_cycle_psel", 64'(psel4), 64'd0);
    check("rsp_cycle_penable", 64'(penable4), 64'd0);
    check("rsp_cycle_paddr", 64'(paddr4), 64'd0);
    check("rsp_cycle_ready", 64'(cmd_ready4), 64'd1);
    pready4 = '0; pslverr4 = '0; prdata4 = '0;
  endtask

  // Scoreboard monitor: pops an expectation whenever a response is presented
  always @(negedge PCLK) begin
    logic [32:0] e;
    if (rsp_valid4) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got err=%0b rdata=%0h expected no response at %0t",
                 rsp_err4, rsp_rdata4, $time);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_err4, rsp_rdata4} !== e) begin
          errors++;
          $display("FAIL rsp_data: got err=%0b rdata=%0h expected err=%0b rdata=%0h at %0t",
                   rsp_err4, rsp_rdata4, e[32], e[31:0], $time);
        end
      end
    end else if (rsp_err4 !== 1'b0 || rsp_rdata4 !== 32'h0) begin
      checks++;
      errors++;
      $display("FAIL rsp_idle_zero: got err=%0b rdata=%0h expected 0 at %0t",
               rsp_err4, rsp_rdata4, $time);
    end
    if ($countones(psel4) > 1 || (penable4 && psel4 == 4'b0)) begin
      checks++;
      errors++;
      $display("FAIL bus_protocol: got psel=%b penable=%b expected one-hot select at %0t",
               psel4, penable4, $time);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{1'b1, 16'h1234, 32'hDEADBEEF, 1, 0, 32'h1111_1111, 1'b0, 1'b0, 32'h0};
    vec[1] = '{1'b0, 16'h3010, 32'h0,        3, 4, 32'hA5A5_0001, 1'b0, 1'b0, 32'hA5A5_0001};
    vec[2] = '{1'b0, 16'h2008, 32'h0,        2, 0, 32'h0000_FFFF, 1'b1, 1'b1, 32'h0};
    vec[3] = '{1'b1, 16'h0004, 32'h0BADF00D, 0, 2, 32'h7777_7777, 1'b1, 1'b1, 32'h0};
    vec[4] = '{1'b0, 16'h0FFC, 32'h0,        0, 1, 32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678};
    vec[5] = '{1'b0, 16'hD1F0, 32'h0,        1, 3, 32'hCAFE_BABE, 1'b0, 1'b0, 32'hCAFE_BABE};
    vec[6] = '{1'b1, 16'h2020, 32'h55AA_55AA, 2, 1, 32'h9999_9999, 1'b0, 1'b0, 32'h0};

    // ---------------- reset state ----------------
    #2 PRESET_n = 1'b0;
    #1;
    check("rst_psel", 64'(psel4), 64'd0);
    check("rst_penable", 64'(penable4), 64'd0);
    check("rst_paddr", 64'(paddr4), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid4), 64'd0);
    repeat (2) @(negedge PCLK);
    PRESET_n = 1'b1;
    @(negedge PCLK);
    check("rst_cmd_ready", 64'(cmd_ready4), 64'd1);
    check("rst_pwdata", 64'(pwdata4), 64'd0);
    check("rst_pwrite", 64'(pwrite4), 64'd0);
    check("rst_cmd_ready3", 64'(cmd_ready3), 64'd1);

    // ---------------- directed transfers ----------------
    for (int n = 0; n < 6; n++) run_xfer(vec[n]);

    // ---------------- decode error + back-to-back (3 slaves) ----------------
    @(negedge PCLK);
    check("dec_ready", 64'(cmd_ready3), 64'd1);
    cmd_valid3 = 1'b1; cmd_write3 = 1'b0; cmd_addr3 = 16'h3000;
    @(negedge PCLK);
    check("dec_rsp_valid", 64'(rsp_valid3), 64'd1);
    check("dec_rsp_err", 64'(rsp_err3), 64'd1);
    check("dec_rsp_rdata", 64'(rsp_rdata3), 64'd0);
    check("dec_psel", 64'(psel3), 64'd0);
    check("dec_ready_held", 64'(cmd_ready3), 64'd1);
    cmd_write3 = 1'b1; cmd_addr3 = 16'h2000; cmd_wdata3 = 32'h600D_CAFE;
    @(negedge PCLK);
    cmd_valid3 = 1'b0;
    check("b2b_psel", 64'(psel3), 64'h4);
    check("b2b_paddr", 64'(paddr3), 64'h2000);
    check("b2b_pwdata", 64'(pwdata3), 64'h600D_CAFE);
    check("b2b_no_rsp", 64'(rsp_valid3), 64'd0);
    pready3 = 3'b100;
    @(negedge PCLK);
    check("b2b_penable", 64'(penable3), 64'd1);
    @(negedge PCLK);
    check("b2b_rsp_valid", 64'(rsp_valid3), 64'd1);
    check("b2b_rsp_err", 64'(rsp_err3), 64'd0);
    check("b2b_psel_idle", 64'(psel3), 64'd0);
    pready3 = '0;

    // ---------------- reset during ACCESS ----------------
    @(negedge PCLK);
    cmd_valid4 = 1'b1; cmd_write4 = 1'b1; cmd_addr4 = 16'h2020; cmd_wdata4 = 32'h1357_9BDF;
    @(negedge PCLK);
    cmd_valid4 = 1'b0;
    pready4 = '0;
    @(negedge PCLK);
    check("mid_penable", 64'(penable4), 64'd1);
    #2 PRESET_n = 1'b0;
    #1;
    check("mid_rst_psel", 64'(psel4), 64'd0);
    check("mid_rst_penable", 64'(penable4), 64'd0);
    check("mid_rst_paddr", 64'(paddr4), 64'd0);
    check("mid_rst_pwdata", 64'(pwdata4), 64'd0);
    check("mid_rst_pwrite", 64'(pwrite4), 64'd0);
    @(negedge PCLK);
    PRESET_n = 1'b1;
    check("mid_rst_no_rsp", 64'(rsp_valid4), 64'd0);
    @(negedge PCLK);
    check("mid_rst_no_rsp2", 64'(rsp_valid4), 64'd0);
    run_xfer(vec[6]);

    // ---------------- stalled slave ----------------
    begin
      int n_acc;
      n_acc = 0;
      @(negedge PCLK);
      check("tmo_ready", 64'(cmd_ready4), 64'd1);
      cmd_valid4 = 1'b1; cmd_write4 = 1'b0; cmd_addr4 = 16'h0040;
`ifdef APB_MASTER_TIMEOUT_EN
      exp_q.push_back({1'b1, 32'h0});
`endif
      @(negedge PCLK);
      cmd_valid4 = 1'b0;
      check("tmo_setup_psel", 64'(psel4), 64'h1);
      pready4 = 4'b1110;
      prdata4 = {4{32'hFEED_FACE}};
      for (int i = 0; i < 100; i++) begin
        @(negedge PCLK);
        if (penable4 !== 1'b1) break;
        n_acc++;
      end
`ifdef APB_MASTER_TIMEOUT_EN
      check("tmo_access_cycles", 64'(n_acc), 64'd16);
      check("tmo_rsp_valid", 64'(rsp_valid4), 64'd1);
      check("tmo_psel_drop", 64'(psel4), 64'd0);
      pready4 = '0; prdata4 = '0;
`else
      check("stall_access_cycles", 64'(n_acc), 64'd100);
      check("stall_psel_held", 64'(psel4), 64'h1);
      pready4 = '0; prdata4 = '0;
      PRESET_n = 1'b0;
      @(negedge PCLK);
      PRESET_n = 1'b1;
`endif
      @(negedge PCLK);
      check("tmo_end_ready", 64'(cmd_ready4), 64'd1);
    end

    repeat (2) @(negedge PCLK);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
